div_seq_ctrl: RTL and testbench

- Control sequencer for the 8-bit restoring-division datapath: M register, A accumulator/adder, Q register, shared ibus/obus.
- Generates the one-hot control strobes c0..c7 in the order load divisor, load dividend, then ITER iterations of shift/subtract/set-quotient-bit/restore, then drives quotient and remainder onto obus.
- Uses a start/done handshake toward the ALU top level and flags divide-by-zero.

---
 rtl/div_seq_ctrl_if.sv | 30 +++
 rtl/div_seq_ctrl.sv | 93 +++++++++
 tb/tb_div_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_ctrl_if.sv
// rtl/div_seq_ctrl_if.sv - control/handshake bundle between the division sequencer and its datapath/top level
interface div_seq_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             sign;
    logic             m_zero;
    logic             c0;
    logic             c1;
    logic             c2;
    logic             c3;
    logic             c4;
    logic             c5;
    logic             c6;
    logic             c7;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter;

    modport master (
        input  start, sign, m_zero,
        output c0, c1, c2, c3, c4, c5, c6, c7, busy, done, err, iter
    );

    modport slave (
        output start, sign, m_zero,
        input  c0, c1, c2, c3, c4, c5, c6, c7, busy, done, err, iter
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - restoring-division control sequencer issuing one-hot strobes c0..c7
module div_seq_ctrl #(
    parameter int ITER  = 8,
    parameter int CNT_W = 3
) (
    input logic            CLK,
    input logic            RESET,
    div_seq_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, LOAD_M, LOAD_Q, SHIFT, SUB, SETQ, RESTORE, OUT_Q, OUT_R, DONE, ERR
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] iter_q;
    logic [CNT_W-1:0] iter_nx;

    always_comb begin
        state_nx = state;
        iter_nx  = iter_q;
        case (state)
            IDLE:    if (bus.start) state_nx = LOAD_M;
            LOAD_M:  state_nx = LOAD_Q;
            LOAD_Q: begin
                iter_nx  = '0;
                state_nx = bus.m_zero ? ERR : SHIFT;
            end
            SHIFT:   state_nx = SUB;
            SUB:     state_nx = SETQ;
            SETQ: begin
                if (bus.sign) begin
                    state_nx = RESTORE;
                end else if (iter_q == LAST) begin
                    state_nx = OUT_Q;
                end else begin
                    state_nx = SHIFT;
                    iter_nx  = iter_q + 1'b1;
                end
            end
            RESTORE: begin
                if (iter_q == LAST) begin
                    state_nx = OUT_Q;
                end else begin
                    state_nx = SHIFT;
                    iter_nx  = iter_q + 1'b1;
                end
            end
            OUT_Q:   state_nx = OUT_R;
            OUT_R:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free and aligned with the state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            iter_q   <= '0;
            bus.c0   <= 1'b0;
            bus.c1   <= 1'b0;
            bus.c2   <= 1'b0;
            bus.c3   <= 1'b0;
            bus.c4   <= 1'b0;
            bus.c5   <= 1'b0;
            bus.c6   <= 1'b0;
            bus.c7   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            state    <= state_nx;
            iter_q   <= iter_nx;
            bus.c0   <= (state_nx == LOAD_M);
            bus.c1   <= (state_nx == LOAD_Q);
            bus.c2   <= (state_nx == SETQ);
            bus.c3   <= (state_nx == SUB);
            bus.c4   <= (state_nx == SHIFT);
            bus.c5   <= (state_nx == RESTORE);
            bus.c6   <= (state_nx == OUT_Q);
            bus.c7   <= (state_nx == OUT_R);
            bus.busy <= (state_nx != IDLE);
            bus.done <= (state_nx == DONE) || (state_nx == ERR);
            bus.err  <= (state_nx == ERR);
        end
    end

    assign bus.iter = iter_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl with a cycle-schedule model and datapath model
module tb_div_seq_ctrl;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    div_seq_ctrl_if #(.CNT_W(3)) bus();
    div_seq_ctrl #(.ITER(8), .CNT_W(3)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    typedef struct {
        logic [7:0] c;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] iter;
        logic       chk_ob;
        logic [7:0] ob;
    } exp_t;

    exp_t       expq[$];
    int         total = 0;
    int         bad = 0;
    logic       chk_en = 1'b0;
    logic [2:0] model_iter = 3'd0;
    int         cyc_ctr = 0;
    int         op_base = 0;
    int         done_cyc[$];
    logic [7:0] cap_q = 8'h00;
    logic [7:0] cap_r = 8'h00;

    logic       dp_mode = 1'b0;
    logic [7:0] sign_pat = 8'h00;
    logic       mz_val = 1'b0;
    logic [7:0] dvd = 8'h00;
    logic [7:0] dvs = 8'h00;
    int         n_c2 = 0;
    int         c2_base = 0;
    logic [2:0] sidx;
    logic [7:0] m_r = 8'h00;
    logic [7:0] q_r = 8'h00;
    logic [8:0] a_r = 9'h000;
    logic [7:0] obus;

    // Behavioural datapath: M, 9-bit A (bit 8 is the sign), Q, shared buses.
    always @(posedge CLK) begin
        if (bus.c2) n_c2 <= n_c2 + 1;
        if (bus.c0) m_r <= dvs;
        if (bus.c1) begin q_r <= dvd; a_r <= 9'h000; end
        if (bus.c4) begin a_r <= {a_r[7:0], q_r[7]}; q_r <= {q_r[6:0], 1'b0}; end
        if (bus.c3) a_r <= a_r - {1'b0, m_r};
        if (bus.c2) q_r[0] <= ~a_r[8];
        if (bus.c5) a_r <= a_r + {1'b0, m_r};
    end

    assign sidx       = 3'(n_c2 - c2_base);
    assign bus.sign   = dp_mode ? a_r[8] : sign_pat[sidx];
    assign bus.m_zero = dp_mode ? (m_r == 8'h00) : mz_val;
    assign obus       = bus.c6 ? q_r : (bus.c7 ? a_r[7:0] : 8'h00);

    function automatic logic [13:0] outs();
        return {bus.c7, bus.c6, bus.c5, bus.c4, bus.c3, bus.c2, bus.c1, bus.c0,
                bus.busy, bus.done, bus.err, bus.iter};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (op cycle %0d)", name, act, exp, cyc_ctr - op_base);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic dn, input logic er, input logic ck, input logic [7:0] ob);
        exp_t e;
        e.c = c; e.busy = 1'b1; e.done = dn; e.err = er; e.iter = model_iter; e.chk_ob = ck; e.ob = ob;
        expq.push_back(e);
    endtask

    task automatic push_idle();
        exp_t e;
        e.c = 8'h00; e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0; e.iter = model_iter; e.chk_ob = 1'b0; e.ob = 8'h00;
        expq.push_back(e);
    endtask

    // Expected per-cycle schedule of one operation; rpat[i]=1 means iteration i restores.
    task automatic model_op(input logic [7:0] rpat, input logic mz, input logic dp, input logic [7:0] qv, input logic [7:0] rv);
        push(8'h01, 1'b0, 1'b0, 1'b0, 8'h00);
        push(8'h02, 1'b0, 1'b0, 1'b0, 8'h00);
        model_iter = 3'd0;
        if (mz) begin
            push(8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            model_iter = 3'(i);
            push(8'h10, 1'b0, 1'b0, 1'b0, 8'h00);
            push(8'h08, 1'b0, 1'b0, 1'b0, 8'h00);
            push(8'h04, 1'b0, 1'b0, 1'b0, 8'h00);
            if (rpat[i]) push(8'h20, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        push(8'h40, 1'b0, 1'b0, dp, qv);
        push(8'h80, 1'b0, 1'b0, dp, rv);
        push(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        int   idx;
        cyc_ctr = cyc_ctr + 1;
        if (chk_en) begin
            idx = cyc_ctr - op_base - 1;
            if (idx >= 0 && idx < expq.size()) begin
                e = expq[idx];
            end else begin
                e.c = 8'h00; e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0;
                e.iter = model_iter; e.chk_ob = 1'b0; e.ob = 8'h00;
            end
            chk("outputs", 32'(outs()), 32'({e.c, e.busy, e.done, e.err, e.iter}));
            chk("onehot", 32'($onehot0({bus.c7, bus.c6, bus.c5, bus.c4, bus.c3, bus.c2, bus.c1, bus.c0})), 32'd1);
            if (e.chk_ob) chk("obus", 32'(obus), 32'(e.ob));
            if (bus.c6) cap_q = obus;
            if (bus.c7) cap_r = obus;
            if (bus.done) done_cyc.push_back(cyc_ctr - op_base);
        end
    end

    task automatic run_op(input logic [7:0] spat, input logic mz, input logic dp, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] qv;
        logic [7:0] rv;
        logic [7:0] rpat;
        qv = 8'h00; rv = 8'h00; rpat = spat;
        if (dp && b != 8'h00) begin
            qv = a / b;
            rv = a % b;
            for (int i = 0; i < 8; i++) rpat[i] = ~qv[7 - i];
        end
        @(negedge CLK); #1;
        dp_mode = dp; sign_pat = spat; mz_val = mz; dvd = a; dvs = b; c2_base = n_c2;
        expq.delete();
        model_op(rpat, mz, dp, qv, rv);
        op_base = cyc_ctr;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (expq.size() + 2) @(negedge CLK);
        #1;
    endtask

    function automatic int last_done(input int back);
        if (done_cyc.size() > back) return done_cyc[done_cyc.size() - 1 - back];
        return -1;
    endfunction

    initial begin
        RESET = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", 32'(outs()), 32'd0);
        @(negedge CLK); #1;
        RESET = 1'b1;
        op_base = cyc_ctr;
        model_iter = 3'd0;
        chk_en = 1'b1;
        repeat (20) @(negedge CLK);
        #1;

        run_op(8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("no_restore_len", 32'(expq.size()), 32'd29);
        chk("no_restore_done", 32'(last_done(0)), 32'd29);

        run_op(8'h00, 1'b0, 1'b1, 8'd100, 8'd7);
        chk("dp_len", 32'(expq.size()), 32'd34);
        chk("dp_done", 32'(last_done(0)), 32'd34);
        chk("dp_quot", 32'(cap_q), 32'd14);
        chk("dp_rem", 32'(cap_r), 32'd2);

        run_op(8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("err_len", 32'(expq.size()), 32'd3);
        chk("err_done", 32'(last_done(0)), 32'd3);
        mz_val = 1'b0;

        // Abort during SUB of iteration 4 (cycle 16).
        @(negedge CLK); #1;
        dp_mode = 1'b0; sign_pat = 8'h00; c2_base = n_c2;
        expq.delete();
        model_op(8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        op_base = cyc_ctr;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge CLK);
        #2;
        chk_en = 1'b0;
        chk("pre_abort_sub", 32'(outs()), 32'({8'h08, 1'b1, 1'b0, 1'b0, 3'd4}));
        RESET = 1'b0;
        #1;
        chk("abort_zero", 32'(outs()), 32'd0);
        expq.delete();
        model_iter = 3'd0;
        @(negedge CLK); #1;
        RESET = 1'b1;
        op_base = cyc_ctr;
        chk_en = 1'b1;

        run_op(8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("post_reset_done", 32'(last_done(0)), 32'd33);

        // start held high: two back-to-back operations, sign alternating 1,0 per SETQ.
        @(negedge CLK); #1;
        dp_mode = 1'b0; sign_pat = 8'h55; c2_base = n_c2;
        expq.delete();
        model_op(8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
        push_idle();
        model_op(8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
        op_base = cyc_ctr;
        bus.start = 1'b1;
        @(posedge CLK);
        repeat (67) @(posedge CLK);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("b2b_len", 32'(expq.size()), 32'd67);
        chk("b2b_done1", 32'(last_done(1)), 32'd33);
        chk("b2b_done2", 32'(last_done(0)), 32'd67);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
